// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared types, segment encodings and helpers for the seven-segment scan driver
package seg7_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEX    = 2'd1,
        ST_CONV   = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Active-low {g,f,e,d,c,b,a} pattern for one hex digit.
    function automatic logic [6:0] seg_lut(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble converter, one input bit per cycle
module bin2bcd_seq #(
    parameter int DATA_W     = 16,
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [DATA_W-1:0]       bin,
    output logic                    done,
    output logic [4*NUM_DIGITS-1:0] bcd
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] bin_q;
    logic [BCD_W-1:0]  bcd_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [BCD_W-1:0]  adj;
    logic [BCD_W-1:0]  bcd_n;

    // Digits that carry out of the top are dropped; the lower digits stay exact.
    always_comb begin
        adj = bcd_q;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (adj[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = adj[4*k +: 4] + 4'd3;
            end
        end
        bcd_n = {adj[BCD_W-2:0], bin_q[DATA_W-1]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bin_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
        end else if (start) begin
            bin_q <= bin;
            bcd_q <= '0;
            cnt_q <= CNT_W'(DATA_W);
        end else if (cnt_q != '0) begin
            bin_q <= bin_q << 1;
            bcd_q <= bcd_n;
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // Flags the final shift cycle; bcd holds the full result from the next cycle on.
    assign done = (cnt_q == CNT_W'(1));
    assign bcd  = bcd_q;

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed seven-segment display driver with hex/decimal conversion
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int DATA_W      = 16,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     value,
    input  logic                  dec_mode,
    input  logic                  blank_lz,
    input  logic [NUM_DIGITS-1:0] dp,
    input  logic                  enable,
    output logic [NUM_DIGITS-1:0] anode,
    output logic [6:0]            seg,
    output logic                  dp_out,
    output logic                  busy,
    output logic                  ovf
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DIG_W = 4 * NUM_DIGITS;
    localparam int EXT_W = (DATA_W > DIG_W) ? DATA_W : DIG_W;
    localparam logic [63:0] DEC_LIMIT = pow10(NUM_DIGITS);

    generate
        if (REFRESH_DIV < DATA_W + 4) begin : g_bad_refresh_div
            $error("seg7_scan_driver: REFRESH_DIV must be at least DATA_W+4");
        end
    endgenerate

    logic [CNT_W-1:0]      cnt_q;
    logic [IDX_W-1:0]      idx_q;
    logic                  first_q;
    state_t                state_q, state_n;
    logic [DATA_W-1:0]     value_q;
    logic                  dec_q;
    logic [NUM_DIGITS-1:0] dp_snap;
    logic [DIG_W-1:0]      digits_q;
    logic                  ovf_q;
    logic [NUM_DIGITS-1:0] anode_q;
    logic [6:0]            seg_q;
    logic                  dp_out_q;

    logic                  tc, wrap, frame_start;
    logic                  busy_c, snap, conv_start, commit;
    logic                  conv_done;
    logic [DIG_W-1:0]      bcd;
    logic [EXT_W-1:0]      value_ext;

    assign tc          = (cnt_q == CNT_W'(REFRESH_DIV - 1));
    assign wrap        = enable && tc && (idx_q == IDX_W'(NUM_DIGITS - 1));
    assign frame_start = first_q || wrap;
    assign value_ext   = EXT_W'(value_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            first_q <= 1'b1;
        end else begin
            first_q <= 1'b0;
            if (enable) begin
                if (tc) begin
                    cnt_q <= '0;
                    idx_q <= wrap ? '0 : idx_q + IDX_W'(1);
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            ST_IDLE:   if (frame_start) state_n = dec_mode ? ST_CONV : ST_HEX;
            ST_HEX:    state_n = ST_COMMIT;
            ST_CONV:   if (conv_done) state_n = ST_COMMIT;
            ST_COMMIT: state_n = ST_IDLE;
            default:   state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_c     = 1'b0;
        snap       = 1'b0;
        conv_start = 1'b0;
        commit     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                snap       = frame_start;
                conv_start = frame_start && dec_mode;
            end
            ST_HEX, ST_CONV: busy_c = 1'b1;
            ST_COMMIT:       commit = 1'b1;
            default: ;
        endcase
    end

    // The converter loads the live value on the same edge the snapshot is taken.
    bin2bcd_seq #(
        .DATA_W     (DATA_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .bin   (value),
        .done  (conv_done),
        .bcd   (bcd)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value_q  <= '0;
            dec_q    <= 1'b0;
            dp_snap  <= '0;
            digits_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (snap) begin
                value_q <= value;
                dec_q   <= dec_mode;
                dp_snap <= dp;
            end
            if (commit) begin
                if (dec_q) begin
                    digits_q <= bcd;
                    ovf_q    <= (64'(value_q) >= DEC_LIMIT);
                end else begin
                    digits_q <= value_ext[DIG_W-1:0];
                    ovf_q    <= ((value_ext >> DIG_W) != '0);
                end
            end
        end
    end

    logic [3:0]            act_digit;
    logic                  lead_zero;
    logic [6:0]            seg_c;
    logic [NUM_DIGITS-1:0] anode_c;
    logic                  dp_c;

    always_comb begin
        act_digit = digits_q[{idx_q, 2'b00} +: 4];
        lead_zero = blank_lz && (idx_q != '0) && ((digits_q >> {idx_q, 2'b00}) == '0);
        if (ovf_q) begin
            seg_c = SEG_DASH;
        end else if (lead_zero) begin
            seg_c = SEG_BLANK;
        end else begin
            seg_c = seg_lut(act_digit);
        end
        anode_c = ~(NUM_DIGITS'(1) << idx_q);
        dp_c    = ~dp_snap[idx_q];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            anode_q  <= '1;
            seg_q    <= SEG_BLANK;
            dp_out_q <= 1'b1;
        end else if (!enable) begin
            anode_q  <= '1;
            seg_q    <= SEG_BLANK;
            dp_out_q <= 1'b1;
        end else begin
            anode_q  <= anode_c;
            seg_q    <= seg_c;
            dp_out_q <= dp_c;
        end
    end

    assign anode  = anode_q;
    assign seg    = seg_q;
    assign dp_out = dp_out_q;
    assign busy   = busy_c;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;

    localparam int ND    = 4;
    localparam int DW    = 16;
    localparam int RD    = 20;
    localparam int FRAME = ND * RD;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] value = '0;
    logic          dec_mode = 1'b0;
    logic          blank_lz = 1'b0;
    logic [ND-1:0] dp = '0;
    logic          enable = 1'b1;
    logic [ND-1:0] anode;
    logic [6:0]    seg;
    logic          dp_out;
    logic          busy;
    logic          ovf;

    int total = 0;
    int bad   = 0;

    logic [6:0] obs_seg [ND];
    logic       obs_dp  [ND];
    bit         seen    [ND];
    int         onehot_err;

    seg7_scan_driver #(
        .NUM_DIGITS  (ND),
        .DATA_W      (DW),
        .REFRESH_DIV (RD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .value    (value),
        .dec_mode (dec_mode),
        .blank_lz (blank_lz),
        .dp       (dp),
        .enable   (enable),
        .anode    (anode),
        .seg      (seg),
        .dp_out   (dp_out),
        .busy     (busy),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    function automatic bit exp_ovf(int v, bit dm);
        return dm ? (v >= 10 ** ND) : (v >= 16 ** ND);
    endfunction

    // Reference: digit k of v in base 10 or 16, with dash/blank rules applied.
    function automatic logic [6:0] exp_seg(int k, int v, bit dm, bit bl);
        int base;
        int p;
        base = dm ? 10 : 16;
        p = base ** k;
        if (exp_ovf(v, dm)) return 7'b0111111;
        if (bl && k > 0 && (v / p) == 0) return 7'b1111111;
        return SEG_TAB[(v / p) % base];
    endfunction

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic decode(output int k);
        int zeros;
        zeros = 0;
        k = -1;
        for (int i = 0; i < ND; i++) begin
            if (anode[i] === 1'b0) begin
                zeros++;
                k = i;
            end else if (anode[i] !== 1'b1) begin
                zeros = 99;
            end
        end
        if (zeros != 1) k = -1;
    endtask

    task automatic observe_frame();
        int k;
        for (int i = 0; i < ND; i++) seen[i] = 0;
        onehot_err = 0;
        repeat (FRAME) begin
            @(negedge clk);
            decode(k);
            if (k < 0) begin
                onehot_err++;
            end else begin
                seen[k]    = 1;
                obs_seg[k] = seg;
                obs_dp[k]  = dp_out;
            end
        end
    endtask

    task automatic check_display(input string tag, input int v, input bit dm, input bit bl,
                                 input logic [ND-1:0] dpv);
        observe_frame();
        chk({tag, "_onehot_err"}, onehot_err, 0);
        chk({tag, "_ovf"}, ovf, exp_ovf(v, dm));
        for (int k = 0; k < ND; k++) begin
            chk($sformatf("%s_seen%0d", tag, k), seen[k], 1);
            chk($sformatf("%s_seg%0d", tag, k), obs_seg[k], exp_seg(k, v, dm, bl));
            chk($sformatf("%s_dp%0d", tag, k), obs_dp[k], !dpv[k]);
        end
    endtask

    task automatic apply(input int v, input bit dm, input bit bl, input logic [ND-1:0] dpv);
        @(negedge clk);
        value    = DW'(v);
        dec_mode = dm;
        blank_lz = bl;
        dp       = dpv;
        repeat (2 * FRAME) @(negedge clk);
    endtask

    task automatic wait_rise(output bit ok);
        bit prev;
        prev = busy;
        ok = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk);
            if (busy && !prev) begin
                ok = 1;
                break;
            end
            prev = busy;
        end
    endtask

    task automatic busy_len(output int len);
        bit ok;
        wait_rise(ok);
        len = -1;
        if (ok) begin
            len = 1;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (!busy) break;
                len++;
            end
        end
    endtask

    initial begin
        int  len;
        int  k;
        int  mism;
        int  v;
        bit  ok;
        bit  dm, bl;
        logic [ND-1:0] dpv;

        // Reset state
        value = 16'hBEEF;
        repeat (3) @(negedge clk);
        chk("rst_anode", anode, 4'hF);
        chk("rst_seg", seg, 7'h7F);
        chk("rst_dp_out", dp_out, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf, 0);

        // Hex BEEF: snapshot on the first cycle after release
        rst = 1'b1;
        busy_len(len);
        chk("hex_busy_len", len, 1);
        repeat (FRAME) @(negedge clk);
        check_display("hex_beef", 16'hBEEF, 0, 0, 4'b0000);
        chk("hex_beef_d0", obs_seg[0], 7'b0001110);
        chk("hex_beef_d3", obs_seg[3], 7'b0000011);

        // Decimal 1234
        apply(1234, 1, 0, 4'b0101);
        busy_len(len);
        chk("dec_busy_len", len, 16);
        check_display("dec_1234", 1234, 1, 0, 4'b0101);

        // Overflow and blanking boundaries
        apply(10000, 1, 0, 4'b0000);
        check_display("dec_10000", 10000, 1, 0, 4'b0000);
        apply(9999, 1, 1, 4'b0000);
        check_display("dec_9999", 9999, 1, 1, 4'b0000);
        apply(7, 1, 1, 4'b1000);
        check_display("dec_7_blank", 7, 1, 1, 4'b1000);
        chk("dec_7_d3", obs_seg[3], 7'b1111111);
        chk("dec_7_d0", obs_seg[0], 7'b1111000);
        apply(0, 1, 1, 4'b0000);
        check_display("dec_0_blank", 0, 1, 1, 4'b0000);
        chk("dec_0_d0", obs_seg[0], 7'b1000000);

        // Display dark while disabled
        @(negedge clk);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        chk("dis_anode", anode, 4'hF);
        chk("dis_seg", seg, 7'h7F);
        chk("dis_dp_out", dp_out, 1);
        enable = 1'b1;

        // Mid-frame value change keeps the committed digits until the next frame
        apply(4321, 1, 0, 4'b0000);
        busy_len(len);
        chk("mid_busy_len", len, 16);
        repeat (10) @(negedge clk);
        value = 16'd5678;
        mism = 0;
        repeat (40) begin
            @(negedge clk);
            decode(k);
            if (k < 0 || seg !== exp_seg(k, 4321, 1, 0)) mism++;
        end
        chk("mid_hold_mismatches", mism, 0);
        repeat (2 * FRAME) @(negedge clk);
        check_display("mid_after", 5678, 1, 0, 4'b0000);

        // Reset in cycle 8 of a conversion
        @(negedge clk);
        value = 16'd9876;
        wait_rise(ok);
        chk("rst_mid_found_conv", ok, 1);
        repeat (7) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_mid_anode", anode, 4'hF);
        chk("rst_mid_seg", seg, 7'h7F);
        chk("rst_mid_dp_out", dp_out, 1);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_ovf", ovf, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_rel_anode", anode, 4'b1110);
        chk("rst_rel_seg_zero", seg, 7'b1000000);
        chk("rst_rel_ovf", ovf, 0);
        repeat (2 * FRAME) @(negedge clk);
        check_display("rst_rel_after", 9876, 1, 0, 4'b0000);

        // Randomized values checked against the arithmetic model
        for (int it = 0; it < 8; it++) begin
            case ($urandom_range(0, 3))
                0: v = int'($urandom_range(0, 65535));
                1: v = int'($urandom_range(0, 99));
                2: v = int'($urandom_range(9990, 10010));
                default: v = int'($urandom_range(0, 15));
            endcase
            dm  = 1'($urandom_range(0, 1));
            bl  = 1'($urandom_range(0, 1));
            dpv = ND'($urandom);
            apply(v, dm, bl, dpv);
            busy_len(len);
            chk($sformatf("rnd%0d_busy_len", it), len, dm ? 16 : 1);
            check_display($sformatf("rnd%0d", it), v, dm, bl, dpv);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, giving the number of multiplexed digits.
REQ-002 SHALL have parameter DATA_W, default 16, giving the width of the displayed binary value.
REQ-003 SHALL have parameter REFRESH_DIV, default 100000, giving clk cycles per digit slot; elaboration SHALL fail if REFRESH_DIV < DATA_W+4.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port value, input, DATA_W bits: the unsigned binary number to display.
REQ-007 SHALL have port dec_mode, input, 1 bit: 1 = decimal display, 0 = hex display.
REQ-008 SHALL have port blank_lz, input, 1 bit: 1 = blank leading zero digits.
REQ-009 SHALL have port dp, input, NUM_DIGITS bits: per-digit decimal point request, active-high.
REQ-010 SHALL have port enable, input, 1 bit: 0 = display dark.
REQ-011 SHALL have port anode, output, NUM_DIGITS bits: one-hot active-low digit select; bit 0 is the rightmost, least significant digit.
REQ-012 SHALL have port seg, output, 7 bits: active-low segments ordered {g,f,e,d,c,b,a}.
REQ-013 SHALL have port dp_out, output, 1 bit: active-low decimal point.
REQ-014 SHALL have port busy, output, 1 bit: high while a conversion is in progress.
REQ-015 SHALL have port ovf, output, 1 bit: the committed value does not fit in NUM_DIGITS digits.

Function
REQ-016 Refresh counter SHALL count 0..REFRESH_DIV-1; at terminal count, digit index SHALL advance 0..NUM_DIGITS-1 and wrap to 0.
REQ-017 Frame start = digit index wraps to 0, or the first cycle after reset release; at frame start the block SHALL snapshot value, dec_mode and dp if FSM is IDLE, else skip the snapshot.
REQ-018 FSM states SHALL be IDLE, HEX, CONV, COMMIT: snapshot -> HEX (dec_mode=0) or CONV (dec_mode=1); HEX -> COMMIT after 1 cycle; CONV -> COMMIT after exactly DATA_W shift-add-3 cycles; COMMIT -> IDLE.
REQ-019 busy SHALL be 1 in HEX and CONV, 0 otherwise.
REQ-020 Digit registers and ovf SHALL update atomically in COMMIT only; display shows the previous committed result until then.
REQ-021 Hex mode: digit k = value[4k+3:4k]; ovf=1 if any value bit at or above 4*NUM_DIGITS is set.
REQ-022 Decimal mode: ovf=1 if value >= 10^NUM_DIGITS; BCD conversion SHALL be double-dabble, one bit per cycle.
REQ-023 ovf=1 SHALL force every digit to dash (seg=7'b0111111), ignoring blanking.
REQ-024 Encoding SHALL be 0..9 = 1000000,1111001,0100100,0110000,0011001,0010010,0000010,1111000,0000000,0010000; A..F = 0001000,0000011,1000110,0100001,0000110,0001110.
REQ-025 blank_lz=1: digits above the most significant non-zero digit SHALL show seg=7'b1111111; digit 0 is never blanked; dp_out still follows dp.
REQ-026 dp_out for the active digit SHALL equal ~dp_snapshot[index].
REQ-027 enable=0 SHALL force anode all-1, seg=7'b1111111, dp_out=1; counters hold; conversion continues.
REQ-028 Outputs anode/seg/dp_out SHALL be registered, lagging the index by one cycle.

Reset
REQ-029 Reset SHALL set anode all-1, seg=7'b1111111, dp_out=1, busy=0, ovf=0, counters 0, digit registers 0, FSM IDLE.
REQ-030 Reset asserted mid-conversion SHALL abort it with no partial commit.

Structure
REQ-031 Package seg7_pkg SHALL hold the FSM state enum, the segment lookup function, and constants SEG_BLANK and SEG_DASH.
REQ-032 Double-dabble SHALL be sub-module bin2bcd_seq (start/done handshake, parameters DATA_W and NUM_DIGITS).

Verification (REFRESH_DIV=20, NUM_DIGITS=4, DATA_W=16)
REQ-033 Bench SHALL check: value=16'hBEEF, dec_mode=0 -> digit0 seg=0001110 with anode=1110, digit3 seg=0000011 with anode=0111, busy high 1 cycle.
REQ-034 Bench SHALL check: value=1234, dec_mode=1 -> digits 0..3 show 4,3,2,1; busy high exactly 16 cycles; ovf=0.
REQ-035 Bench SHALL check: value=10000, dec_mode=1 -> ovf=1, all four digits seg=0111111.
REQ-036 Bench SHALL check: value=7, dec_mode=1, blank_lz=1 -> digits 3..1 seg=1111111, digit0 seg=1111000; value=0 -> digit0 seg=1000000.
REQ-037 Bench SHALL check: rst low at cycle 8 of a conversion -> outputs at reset values in the same cycle, digit registers 0 after release.
REQ-038 Bench SHALL check: value changed mid-frame -> display unchanged until the commit following the next frame start.
